// File: rtl/sum_expander_if.sv
// sum_expander_if: handshake bundle for the sum expander.
// Carries the count input channel (in_*), the serial bit output channel
// (out_*), the latched thermometer word and the sticky overflow flag.
// The master side drives sums and consumes bits; the slave side is the expander.
interface sum_expander_if #(
    parameter int N = 5,
    parameter int W = 3
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_sum;
    logic         out_valid;
    logic         out_ready;
    logic         out_bit;
    logic         out_last;
    logic [N-1:0] out_word;
    logic         err_ovf;

    modport master (
        output in_valid,
        output in_sum,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bit,
        input  out_last,
        input  out_word,
        input  err_ovf
    );

    modport slave (
        input  in_valid,
        input  in_sum,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bit,
        output out_last,
        output out_word,
        output err_ovf
    );
endinterface

// File: rtl/sum_expander.sv
// sum_expander: re-expands a W-bit population count into an N-bit
// thermometer word and replays it serially, lane 0 first, one bit per
// accepted output beat.
// Optional feature macro: SUM_EXPANDER_OVF_EN -- when defined, a count
// above N sets the sticky err_ovf flag; otherwise err_ovf is tied low.
// Saturation of the data word does not depend on the macro: the thermometer
// builder already yields all ones for any count >= N.
module sum_expander #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    sum_expander_if.slave    bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [IW-1:0] IDX_ZERO = IW'(0);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_word;
    logic [IW-1:0] r_idx;
    logic          r_bit;
    logic          r_last;

    logic [N-1:0]  w_word_nxt;
    logic [IW-1:0] w_idx_nxt;

    // Thermometer code: lane i is set when i < k, so k >= N saturates to all ones.
    function automatic logic [N-1:0] thermo(input logic [W-1:0] k);
        logic [N-1:0] t;
        t = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            t[i] = (i < int'(k));
        end
        return t;
    endfunction

    assign w_word_nxt = thermo(bus.in_sum);
    assign w_idx_nxt  = r_idx + IDX_ONE;

    // Control/data FSM: accept a sum in IDLE, then replay the word bit by bit.
    // out_bit/out_last are precomputed so they stay registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_word  <= {N{1'b0}};
            r_idx   <= IDX_ZERO;
            r_bit   <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_state <= ST_SHIFT;
                        r_word  <= w_word_nxt;
                        r_idx   <= IDX_ZERO;
                        r_bit   <= w_word_nxt[0];
                        r_last  <= (IDX_LAST == IDX_ZERO);
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (bus.out_ready) begin
                        if (r_last) begin
                            // Final lane consumed: clear the bit outputs, keep the word.
                            r_state <= ST_IDLE;
                            r_bit   <= 1'b0;
                            r_last  <= 1'b0;
                        end else begin
                            r_idx   <= w_idx_nxt;
                            r_bit   <= r_word[w_idx_nxt];
                            r_last  <= (w_idx_nxt == IDX_LAST);
                        end
                    end else begin
                        r_state <= ST_SHIFT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_bit   <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SUM_EXPANDER_OVF_EN
    localparam logic [W-1:0] N_W = W'(N);
    logic r_ovf;

    // Sticky overflow: set on any accepted count above N, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if ((r_state == ST_IDLE) && bus.in_valid && (bus.in_sum > N_W)) begin
            r_ovf <= 1'b1;
        end else begin
            r_ovf <= r_ovf;
        end
    end

    assign bus.err_ovf = r_ovf;
`else
    assign bus.err_ovf = 1'b0;
`endif

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_SHIFT);
    assign bus.out_bit   = r_bit;
    assign bus.out_last  = r_last;
    assign bus.out_word  = r_word;

endmodule

// File: tb/tb_sum_expander.sv
// tb_sum_expander: directed, table-driven bench for sum_expander (N=5, W=3).
// Expected overflow behaviour follows SUM_EXPANDER_OVF_EN as seen by this file.
module tb_sum_expander;
    localparam int N = 5;
    localparam int W = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic ovf_model;

    sum_expander_if #(.N(N), .W(W)) bus ();

    sum_expander #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] sum;
        logic [4:0] word;
    } vec_t;

    vec_t vecs [7];

`ifdef SUM_EXPANDER_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    // Free-running clock, 10 time units period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop if something stalls far beyond the expected run length.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for in_ready, present the sum for one edge, return one
    // negedge after the accept edge (cycle k+1).
    task automatic send(input logic [2:0] s);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("send_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_sum   = s;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sum   = 3'd0;
        if (s > 3'd5 && OVF_EN) ovf_model = 1'b1;
    endtask

    // Collect N beats at out_ready=1 starting in cycle k+1, then check the IDLE cycle.
    task automatic collect(input string tag, input logic [4:0] w);
        bus.out_ready = 1'b1;
        for (int b = 0; b < N; b++) begin
            chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
            chk({tag, "_bit"},   {31'd0, bus.out_bit},   {31'd0, w[b]});
            chk({tag, "_last"},  {31'd0, bus.out_last},  (b == N - 1) ? 32'd1 : 32'd0);
            chk({tag, "_word"},  {27'd0, bus.out_word},  {27'd0, w});
            chk({tag, "_ovf"},   {31'd0, bus.err_ovf},   {31'd0, ovf_model});
            @(negedge clk);
        end
        chk({tag, "_idle_ready"}, {31'd0, bus.in_ready},  32'd1);
        chk({tag, "_idle_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_idle_bit"},   {31'd0, bus.out_bit},   32'd0);
        chk({tag, "_idle_last"},  {31'd0, bus.out_last},  32'd0);
        chk({tag, "_idle_word"},  {27'd0, bus.out_word},  {27'd0, w});
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd1);
        chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_out_bit"},   {31'd0, bus.out_bit},   32'd0);
        chk({tag, "_out_last"},  {31'd0, bus.out_last},  32'd0);
        chk({tag, "_out_word"},  {27'd0, bus.out_word},  32'd0);
        chk({tag, "_err_ovf"},   {31'd0, bus.err_ovf},   32'd0);
    endtask

    // Main stimulus sequence.
    initial begin
        logic [6:0] bp_ready;
        logic [4:0] bp_word;
        int         beats;

        checks    = 0;
        failures  = 0;
        ovf_model = 1'b0;

        vecs[0] = '{sum: 3'd3, word: 5'b00111};
        vecs[1] = '{sum: 3'd0, word: 5'b00000};
        vecs[2] = '{sum: 3'd5, word: 5'b11111};
        vecs[3] = '{sum: 3'd1, word: 5'b00001};
        vecs[4] = '{sum: 3'd4, word: 5'b01111};
        vecs[5] = '{sum: 3'd7, word: 5'b11111};
        vecs[6] = '{sum: 3'd2, word: 5'b00011};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sum    = 3'd0;
        bus.out_ready = 1'b0;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        // Nominal vectors, including zero, full and overflow (sticky afterwards).
        for (int v = 0; v < 7; v++) begin
            send(vecs[v].sum);
            collect($sformatf("vec%0d", v), vecs[v].word);
        end
        chk("ovf_sticky", {31'd0, bus.err_ovf}, {31'd0, OVF_EN});

        // Reset clears the sticky flag.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ovf_model = 1'b0;
        check_reset_state("reset2");

        // Backpressure: sum=2 with out_ready 1,0,0,1,1,1,1; in_valid with sum=5
        // held high during SHIFT must be ignored.
        bp_ready = 7'b1111001;
        bp_word  = 5'b00011;
        beats    = 0;
        send(3'd2);
        bus.in_valid = 1'b1;
        bus.in_sum   = 3'd5;
        for (int c = 0; c < 7; c++) begin
            bus.out_ready = bp_ready[c];
            if (c == 6) begin
                bus.in_valid = 1'b0;
                bus.in_sum   = 3'd0;
            end
            chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_bit",   {31'd0, bus.out_bit},   {31'd0, bp_word[beats]});
            chk("bp_last",  {31'd0, bus.out_last},  (beats == N - 1) ? 32'd1 : 32'd0);
            chk("bp_word",  {27'd0, bus.out_word},  {27'd0, bp_word});
            if (bus.out_valid && bp_ready[c]) beats++;
            @(negedge clk);
        end
        chk("bp_beats",      beats,                   32'd5);
        chk("bp_idle_ready", {31'd0, bus.in_ready},   32'd1);
        chk("bp_idle_word",  {27'd0, bus.out_word},   {27'd0, bp_word});
        chk("bp_ovf",        {31'd0, bus.err_ovf},    32'd0);

        // Reset mid-shift: sum=4, two beats, then reset; a fresh sum=1 follows.
        send(3'd4);
        bus.out_ready = 1'b1;
        chk("mid_bit0", {31'd0, bus.out_bit}, 32'd1);
        @(negedge clk);
        chk("mid_bit1", {31'd0, bus.out_bit}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        check_reset_state("mid_reset");
        send(3'd1);
        collect("after_mid", 5'b00001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
